digit_serial_addsub16: RTL



---
 rtl/digit_serial_addsub16.sv | 135 +++++++++++++
 1 files changed

// File: rtl/digit_serial_addsub16.sv
// Digit-serial 16-bit adder/subtractor: one 4-bit digit per clock, LSD first, start/done handshake.
// Optional zero-result flag output enabled by defining DSAS16_ZERO_FLAG_EN.
module digit_serial_addsub16 #(
  parameter int DIGIT_W = 4,  // fixed at 4; other values are unsupported
  parameter int WIDTH   = 16  // must equal 4*DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
`ifdef DSAS16_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse and
  // s/cout/ovf are valid from that pulse until the next accepted start.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry;
  logic [1:0]         cnt;
  logic [DIGIT_W-1:0] a_dig;
  logic [DIGIT_W-1:0] b_dig;
  logic [DIGIT_W:0]   sum5;
  logic               last_digit;
`ifdef DSAS16_ZERO_FLAG_EN
  logic               zacc;
  logic               dig_zero;
`endif

  assign state_dbg  = state;
  assign last_digit = (cnt == 2'd3);

  always_comb begin
    a_dig = a_reg[3:0];
    b_dig = b_reg[3:0];
    case (cnt)
      2'd0: begin a_dig = a_reg[3:0];   b_dig = b_reg[3:0];   end
      2'd1: begin a_dig = a_reg[7:4];   b_dig = b_reg[7:4];   end
      2'd2: begin a_dig = a_reg[11:8];  b_dig = b_reg[11:8];  end
      default: begin a_dig = a_reg[15:12]; b_dig = b_reg[15:12]; end
    endcase
  end

  assign sum5 = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, carry};

`ifdef DSAS16_ZERO_FLAG_EN
  assign dig_zero = (sum5[DIGIT_W-1:0] == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      cnt   <= 2'd0;
`ifdef DSAS16_ZERO_FLAG_EN
      zero  <= 1'b0;
      zacc  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= 2'd0;
            busy  <= 1'b1;
            state <= RUN;
`ifdef DSAS16_ZERO_FLAG_EN
            zacc  <= 1'b1;
`endif
          end
        end
        RUN: begin
          case (cnt)
            2'd0:    s[3:0]   <= sum5[3:0];
            2'd1:    s[7:4]   <= sum5[3:0];
            2'd2:    s[11:8]  <= sum5[3:0];
            default: s[15:12] <= sum5[3:0];
          endcase
          carry <= sum5[DIGIT_W];
          cnt   <= cnt + 2'd1;
`ifdef DSAS16_ZERO_FLAG_EN
          zacc  <= zacc & dig_zero;
`endif
          // Flags are registered on the last digit so they are valid together with done.
          if (last_digit) begin
            state <= DONE;
            done  <= 1'b1;
            cout  <= sum5[DIGIT_W];
            ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum5[DIGIT_W-1] != a_reg[WIDTH-1]);
`ifdef DSAS16_ZERO_FLAG_EN
            zero  <= zacc & dig_zero;
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
